calc_op_sequencer: RTL

//  Sequences one calculator operation at a time between the keypad/operand front end and a multi-cycle ALU.

---
 rtl/calc_pkg.sv | 37 +++
 rtl/calc_range_chk.sv | 30 +++
 rtl/calc_op_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode, error-code and state encodings for the calculator
package calc_pkg;

    localparam logic [2:0] OP_EQU   = 3'd0;
    localparam logic [2:0] OP_TIMES = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_PLUS  = 3'd3;
    localparam logic [2:0] OP_MINUS = 3'd4;
    localparam logic [2:0] OP_MOD   = 3'd5;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_DIV0  = 3'd1,
        ERR_OVF   = 3'd2,
        ERR_BADOP = 3'd3,
        ERR_TMO   = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } seq_state_e;

    // Opcodes 6 and 7 have no meaning anywhere in the calculator.
    function automatic logic is_bad_op(input logic [2:0] op);
        return op > OP_MOD;
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/calc_range_chk.sv
// rtl/calc_range_chk.sv - display-range test on a two's complement value
//
// Purpose: flags whether r fits the FND display: 0..RES_POS_MAX for
// non-negative values, magnitude up to RES_NEG_MAX for negative values.
// Ports:
//   r         in  W  value under test (two's complement)
//   in_range  out 1  r can be displayed
module calc_range_chk #(
    parameter int W           = 32,
    parameter int RES_POS_MAX = 999_999,
    parameter int RES_NEG_MAX = 99_999
) (
    input  logic [W-1:0] r,
    output logic         in_range
);

    logic         neg;
    logic [W:0]   r_ext;
    logic [W:0]   mag;
    logic [W:0]   lim;

    assign neg   = r[W-1];
    assign r_ext = {r[W-1], r};
    // One extra bit so the most negative value yields a positive magnitude
    // larger than any limit instead of wrapping back to itself.
    assign mag      = neg ? (~r_ext + (W+1)'(1)) : r_ext;
    assign lim      = neg ? (W+1)'(RES_NEG_MAX) : (W+1)'(RES_POS_MAX);
    assign in_range = (mag <= lim);

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - issues one calculator operation to the ALU and commits ans
//
// Purpose: accepts {op, a, b}, screens BADOP/DIV0, issues the ALU with a
// one-cycle start, waits for done, range-checks the result and holds ans.
// Optional macro CALC_TIMEOUT_EN adds a WAIT-state timeout with alu_abort.
// Ports:
//   sw_clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready/req_op/a/b    operation request handshake
//   alu_start/alu_op/alu_a/alu_b      ALU issue
//   alu_done/alu_result/alu_abort     ALU completion / abort
//   ans/ans_valid                     committed result and its pulse
//   busy/err/err_code/err_clr         status and error handling
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int W           = 32,
    parameter int RES_POS_MAX = 999_999,
    parameter int RES_NEG_MAX = 99_999
`ifdef CALC_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic         sw_clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         alu_start,
    output logic [2:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    output logic         alu_abort,
    output logic [W-1:0] ans,
    output logic         ans_valid,
    output logic         busy,
    output logic         err,
    output logic [2:0]   err_code,
    input  logic         err_clr
);

    seq_state_e   state_q, state_d;
    err_code_e    err_code_q;
    err_code_e    err_set_val;
    logic         err_set;
    logic         accept;
    logic         in_range;
    logic         abort;
    logic [W-1:0] res_q;

    calc_range_chk #(
        .W           (W),
        .RES_POS_MAX (RES_POS_MAX),
        .RES_NEG_MAX (RES_NEG_MAX)
    ) u_range_chk (
        .r        (res_q),
        .in_range (in_range)
    );

`ifdef CALC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             wait_expired;

    // Counts WAIT cycles already spent; expiry fires on the TIMEOUT_CYC-th one.
    assign wait_expired = (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge sw_clk) begin
        if (rst || state_q != ST_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end
`endif

    assign accept    = req_valid && (state_q == ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);
    assign alu_start = (state_q == ST_ISSUE);
    assign ans_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign err       = (state_q == ST_ERROR);
    assign err_code  = err_code_q;
    assign alu_abort = abort;

    always_comb begin
        state_d     = state_q;
        err_set     = 1'b0;
        err_set_val = ERR_NONE;
        abort       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_op == OP_EQU) begin
                        state_d = ST_DONE;
                    end else if (is_bad_op(req_op)) begin
                        state_d     = ST_ERROR;
                        err_set     = 1'b1;
                        err_set_val = ERR_BADOP;
                    end else if (is_div_op(req_op) && req_b == '0) begin
                        state_d     = ST_ERROR;
                        err_set     = 1'b1;
                        err_set_val = ERR_DIV0;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A done arriving on the expiry cycle still wins.
                if (alu_done) begin
                    state_d = ST_CHECK;
                end
`ifdef CALC_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d     = ST_ERROR;
                    err_set     = 1'b1;
                    err_set_val = ERR_TMO;
                    abort       = 1'b1;
                end
`endif
            end
            ST_CHECK: begin
                if (in_range) begin
                    state_d = ST_DONE;
                end else begin
                    state_d     = ST_ERROR;
                    err_set     = 1'b1;
                    err_set_val = ERR_OVF;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: begin
                if (err_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sw_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            err_code_q <= ERR_NONE;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            res_q      <= '0;
            ans        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_op <= req_op;
                alu_a  <= req_a;
                alu_b  <= req_b;
            end
            if (state_q == ST_WAIT && alu_done) begin
                res_q <= alu_result;
            end
            if (state_q == ST_CHECK && in_range) begin
                ans <= res_q;
            end
            if (err_set) begin
                err_code_q <= err_set_val;
            end else if (state_q == ST_ERROR && err_clr) begin
                err_code_q <= ERR_NONE;
            end
        end
    end

endmodule
